// File: rtl/pipe_hazard_ctrl.sv
// Hazard/sequencing controller for the 5-stage pipeline: load-use and HI/LO busy stalls,
// taken-branch flushes, halt-syscall drain, and saturating stall/flush counters.
module pipe_hazard_ctrl #(
  parameter int MD_LAT    = 5,
  parameter int DRAIN_CYC = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        id_valid,
  input  logic [5:0]  id_op,
  input  logic [5:0]  id_func,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic        id_uses_rs,
  input  logic        id_uses_rt,
  input  logic        ex_memread,
  input  logic [4:0]  ex_wreg,
  input  logic        ex_branch_taken,
  input  logic        sys_v0_is_10,
  input  logic        resume,
  output logic        pc_en,
  output logic        ifid_en,
  output logic        ifid_flush,
  output logic        idex_flush,
  output logic        halted,
  output logic [15:0] stall_cnt,
  output logic [15:0] flush_cnt
);

  // state  | meaning
  // RUN    | normal issue; stalls, flushes and halt detection active
  // DRAIN  | halt accepted; front end frozen while the syscall reaches WB
  // HALTED | pipeline frozen until a resume pulse
  typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;

  state_t      state;
  logic [3:0]  md_cnt;
  logic [2:0]  drain_cnt;

  logic is_rtype, mfhilo, muldiv, syscall, md_busy;
  logic load_use, md_stall, stall;
  logic in_run, br_run, stall_run, halt_req, md_load;

  assign is_rtype = (id_op == 6'h00);
  assign mfhilo   = is_rtype & ((id_func == 6'h10) | (id_func == 6'h12));
  assign muldiv   = is_rtype & (id_func[5:2] == 4'b0110);
  assign syscall  = is_rtype & (id_func == 6'h0C);
  assign md_busy  = (md_cnt != 4'd0);

  assign load_use = id_valid & ex_memread & (ex_wreg != 5'd0) &
                    ((id_uses_rs & (id_rs == ex_wreg)) | (id_uses_rt & (id_rt == ex_wreg)));
  assign md_stall = id_valid & (mfhilo | muldiv) & md_busy;
  assign stall    = load_use | md_stall;

  assign in_run    = (state == RUN);
  assign br_run    = in_run & ex_branch_taken;
  assign stall_run = in_run & ~ex_branch_taken & stall;
  assign halt_req  = in_run & ~ex_branch_taken & ~stall & id_valid & syscall & sys_v0_is_10;
  assign md_load   = in_run & id_valid & muldiv & ~stall & ~ex_branch_taken;

  // Outputs are gated by rst_n so they read 0 the moment reset asserts.
  always_comb begin
    pc_en      = 1'b0;
    ifid_en    = 1'b0;
    ifid_flush = 1'b0;
    idex_flush = 1'b0;
    halted     = 1'b0;
    if (rst_n) begin
      case (state)
        RUN: begin
          if (ex_branch_taken) begin
            pc_en      = 1'b1;
            ifid_en    = 1'b1;
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
          end else if (stall) begin
            idex_flush = 1'b1;
          end else if (halt_req) begin
            ifid_en    = 1'b1;
            ifid_flush = 1'b1;
          end else begin
            pc_en   = 1'b1;
            ifid_en = 1'b1;
          end
        end
        DRAIN: begin
          ifid_flush = 1'b1;
          idex_flush = 1'b1;
        end
        HALTED:  halted = 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= RUN;
      md_cnt    <= 4'd0;
      drain_cnt <= 3'd0;
      stall_cnt <= 16'd0;
      flush_cnt <= 16'd0;
    end else begin
      if (md_load)      md_cnt <= 4'(MD_LAT);
      else if (md_busy) md_cnt <= md_cnt - 4'd1;

      if (stall_run && stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'd1;
      if (br_run && flush_cnt != 16'hFFFF)    flush_cnt <= flush_cnt + 16'd1;

      case (state)
        RUN: begin
          if (halt_req) begin
            state     <= DRAIN;
            drain_cnt <= 3'(DRAIN_CYC - 1);
          end
        end
        DRAIN: begin
          if (drain_cnt == 3'd0) state <= HALTED;
          else                   drain_cnt <= drain_cnt - 3'd1;
        end
        HALTED: begin
          if (resume) state <= RUN;
        end
        default: state <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: per-cycle expected output vectors are queued with the
// stimulus and popped at the falling edge; counters are tracked by the bench.
module tb_pipe_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        id_valid;
  logic [5:0]  id_op, id_func;
  logic [4:0]  id_rs, id_rt;
  logic        id_uses_rs, id_uses_rt;
  logic        ex_memread;
  logic [4:0]  ex_wreg;
  logic        ex_branch_taken, sys_v0_is_10, resume;
  logic        pc_en, ifid_en, ifid_flush, idex_flush, halted;
  logic [15:0] stall_cnt, flush_cnt;

  int errors = 0;
  int checks = 0;
  int exp_stall = 0;
  int exp_flush = 0;
  logic [4:0] sb[$];

  // {pc_en, ifid_en, ifid_flush, idex_flush, halted}
  localparam logic [4:0] O_ZERO  = 5'b00000;
  localparam logic [4:0] O_RUN   = 5'b11000;
  localparam logic [4:0] O_STALL = 5'b00010;
  localparam logic [4:0] O_BR    = 5'b11110;
  localparam logic [4:0] O_SYS   = 5'b01100;
  localparam logic [4:0] O_DRAIN = 5'b00110;
  localparam logic [4:0] O_HALT  = 5'b00001;

  wire [4:0] outs = {pc_en, ifid_en, ifid_flush, idex_flush, halted};

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.MD_LAT(5), .DRAIN_CYC(3)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_op(id_op), .id_func(id_func),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .ex_memread(ex_memread), .ex_wreg(ex_wreg), .ex_branch_taken(ex_branch_taken),
    .sys_v0_is_10(sys_v0_is_10), .resume(resume), .pc_en(pc_en), .ifid_en(ifid_en),
    .ifid_flush(ifid_flush), .idex_flush(idex_flush), .halted(halted),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  task automatic idle();
    id_valid = 0; id_op = 0; id_func = 0; id_rs = 0; id_rt = 0;
    id_uses_rs = 0; id_uses_rt = 0; ex_memread = 0; ex_wreg = 0;
    ex_branch_taken = 0; sys_v0_is_10 = 0; resume = 0;
  endtask

  task automatic next_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic load_use_inputs();
    id_valid = 1; id_op = 6'h00; id_func = 6'h20;
    id_rs = 5'd8; id_uses_rs = 1; ex_memread = 1; ex_wreg = 5'd8;
  endtask

  task automatic test_reset();
    rst_n = 0;
    idle();
    #3;
    checks++;
    if (outs !== O_ZERO) begin errors++; $display("FAIL reset_outs got=%b exp=%b", outs, O_ZERO); end
    checks++;
    if (stall_cnt !== 16'd0 || flush_cnt !== 16'd0) begin
      errors++; $display("FAIL reset_cnt got=%h/%h exp=0/0", stall_cnt, flush_cnt);
    end
    @(negedge clk);
    rst_n = 1;
    next_edge(); idle(); sb.push_back(O_RUN);
    @(negedge clk);
    checks++;
    if (outs !== sb[0]) begin errors++; $display("FAIL reset_release got=%b exp=%b", outs, sb[0]); end
    void'(sb.pop_front());
  endtask

  task automatic test_load_use();
    logic [4:0] exp;
    for (int i = 0; i < 4; i++) begin
      next_edge(); idle(); load_use_inputs();
      case (i)
        0: begin sb.push_back(O_STALL); exp_stall++; end
        1: begin id_rs = 5'd0; ex_wreg = 5'd0; sb.push_back(O_RUN); end
        2: begin id_rs = 5'd9; id_rt = 5'd8; id_uses_rt = 0; sb.push_back(O_RUN); end
        default: begin id_rs = 5'd9; id_rt = 5'd8; id_uses_rt = 1; sb.push_back(O_STALL); exp_stall++; end
      endcase
      @(negedge clk);
      exp = sb.pop_front();
      checks++;
      if (outs !== exp) begin errors++; $display("FAIL load_use[%0d] got=%b exp=%b", i, outs, exp); end
    end
    next_edge(); idle();
    checks++;
    if (stall_cnt !== 16'(exp_stall)) begin
      errors++; $display("FAIL load_use_cnt got=%0d exp=%0d", stall_cnt, exp_stall);
    end
  endtask

  task automatic test_branch_over_stall();
    logic [4:0] exp;
    load_use_inputs(); ex_branch_taken = 1; sb.push_back(O_BR); exp_flush++;
    @(negedge clk);
    exp = sb.pop_front();
    checks++;
    if (outs !== exp) begin errors++; $display("FAIL branch_stall got=%b exp=%b", outs, exp); end
    next_edge(); idle();
    checks++;
    if (stall_cnt !== 16'(exp_stall) || flush_cnt !== 16'(exp_flush)) begin
      errors++;
      $display("FAIL branch_cnt got=%0d/%0d exp=%0d/%0d", stall_cnt, flush_cnt, exp_stall, exp_flush);
    end
  endtask

  task automatic test_muldiv();
    logic [4:0] exp;
    for (int i = 0; i < 7; i++) begin
      if (i > 0) next_edge();
      idle(); id_valid = 1; id_op = 6'h00;
      if (i == 0) begin
        id_func = 6'h18; sb.push_back(O_RUN);
      end else begin
        id_func = 6'h12;
        if (i <= 5) begin sb.push_back(O_STALL); exp_stall++; end
        else sb.push_back(O_RUN);
      end
      @(negedge clk);
      exp = sb.pop_front();
      checks++;
      if (outs !== exp) begin errors++; $display("FAIL muldiv[%0d] got=%b exp=%b", i, outs, exp); end
    end
    next_edge(); idle();
    checks++;
    if (stall_cnt !== 16'(exp_stall)) begin
      errors++; $display("FAIL muldiv_cnt got=%0d exp=%0d", stall_cnt, exp_stall);
    end
  endtask

  task automatic test_halt();
    logic [4:0] exp;
    for (int i = 0; i < 8; i++) begin
      if (i > 0) next_edge();
      idle();
      case (i)
        0: begin id_valid = 1; id_func = 6'h0C; sys_v0_is_10 = 0; resume = 1; sb.push_back(O_RUN); end
        1: begin id_valid = 1; id_func = 6'h0C; sys_v0_is_10 = 1; sb.push_back(O_SYS); end
        2, 3, 4: begin ex_branch_taken = 1; sb.push_back(O_DRAIN); end
        5: begin load_use_inputs(); sb.push_back(O_HALT); end
        6: begin resume = 1; sb.push_back(O_HALT); end
        default: sb.push_back(O_RUN);
      endcase
      @(negedge clk);
      exp = sb.pop_front();
      checks++;
      if (outs !== exp) begin errors++; $display("FAIL halt[%0d] got=%b exp=%b", i, outs, exp); end
    end
    next_edge(); idle();
    checks++;
    if (stall_cnt !== 16'(exp_stall) || flush_cnt !== 16'(exp_flush)) begin
      errors++;
      $display("FAIL halt_cnt got=%0d/%0d exp=%0d/%0d", stall_cnt, flush_cnt, exp_stall, exp_flush);
    end
  endtask

  task automatic test_reset_mid_drain();
    logic [4:0] exp;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) next_edge();
      idle(); id_valid = 1;
      case (i)
        0: begin id_func = 6'h18; sb.push_back(O_RUN); end
        1: begin id_func = 6'h0C; sys_v0_is_10 = 1; sb.push_back(O_SYS); end
        default: begin id_valid = 0; sb.push_back(O_DRAIN); end
      endcase
      @(negedge clk);
      exp = sb.pop_front();
      checks++;
      if (outs !== exp) begin errors++; $display("FAIL mid_drain[%0d] got=%b exp=%b", i, outs, exp); end
    end
    next_edge(); idle();
    rst_n = 0;
    exp_stall = 0; exp_flush = 0;
    #1;
    checks++;
    if (outs !== O_ZERO) begin errors++; $display("FAIL async_reset got=%b exp=%b", outs, O_ZERO); end
    checks++;
    if (stall_cnt !== 16'd0 || flush_cnt !== 16'd0) begin
      errors++; $display("FAIL async_reset_cnt got=%h/%h exp=0/0", stall_cnt, flush_cnt);
    end
    @(negedge clk);
    rst_n = 1;
    next_edge(); idle(); id_valid = 1; id_func = 6'h12; sb.push_back(O_RUN);
    @(negedge clk);
    exp = sb.pop_front();
    checks++;
    if (outs !== exp) begin errors++; $display("FAIL post_reset_mflo got=%b exp=%b", outs, exp); end
  endtask

  task automatic test_saturation();
    next_edge(); idle(); load_use_inputs();
    repeat (70000) @(posedge clk);
    #1;
    checks++;
    if (outs !== O_STALL) begin errors++; $display("FAIL sat_outs got=%b exp=%b", outs, O_STALL); end
    checks++;
    if (stall_cnt !== 16'hFFFF) begin errors++; $display("FAIL sat_cnt got=%h exp=FFFF", stall_cnt); end
    idle();
    next_edge();
    checks++;
    if (stall_cnt !== 16'hFFFF) begin errors++; $display("FAIL sat_hold got=%h exp=FFFF", stall_cnt); end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_branch_over_stall();
    test_muldiv();
    test_halt();
    test_reset_mid_drain();
    test_saturation();
    checks++;
    if (sb.size() != 0) begin errors++; $display("FAIL scoreboard_left got=%0d exp=0", sb.size()); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
